// File: rtl/cim_array_seq_if.sv
// Command handshake and array-control bundle for the sequenced CIM bank/column controller.
interface cim_array_seq_if #(
   parameter int BANKS  = 16,
   parameter int COLS   = 8,
   parameter int DATA_W = 16
);
   localparam int BA_W = $clog2(BANKS);
   localparam int CA_W = $clog2(COLS);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [BA_W-1:0]   cmd_bank;
   logic [CA_W-1:0]   cmd_col;
   logic [DATA_W-1:0] cmd_data_bank;
   logic [DATA_W-1:0] cmd_data_in;

   logic              preb_en;
   logic              mac_en;
   logic              w_en;
   logic [BANKS-1:0]  bank_mux;
   logic [DATA_W-1:0] data_op;
   logic [COLS-1:0]   col_mux;
   logic [DATA_W-1:0] data_and;
   logic              done;
   logic              err;

   modport master (
      output cmd_valid, cmd_op, cmd_bank, cmd_col, cmd_data_bank, cmd_data_in,
      input  cmd_ready, preb_en, mac_en, w_en, bank_mux, data_op,
             col_mux, data_and, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_bank, cmd_col, cmd_data_bank, cmd_data_in,
      output cmd_ready, preb_en, mac_en, w_en, bank_mux, data_op,
             col_mux, data_and, done, err
   );
endinterface

// File: rtl/cim_array_seq.sv
// Sequenced CIM array controller: latches one command, runs PRE -> EXEC -> DRAIN,
// driving bank-side controls and, one cycle later, the adder-tree-side controls.
module cim_array_seq #(
   parameter int BANKS  = 16,
   parameter int COLS   = 8,
   parameter int DATA_W = 16,
   parameter int WR_W   = 8,
   parameter int RD_W   = 4
) (
   input logic            clk,
   input logic            rst,
   cim_array_seq_if.slave bus
);
   localparam int BA_W = $clog2(BANKS);
   localparam int CA_W = $clog2(COLS);

   typedef enum logic [1:0] {IDLE, PRE, EXEC, DRAIN} state_t;
   typedef enum logic [1:0] {OP_MAC = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_NOP = 2'b11} op_t;

   state_t            state, state_nx;
   op_t               op_q;
   logic [BA_W-1:0]   bank_q;
   logic [CA_W-1:0]   col_q;
   logic [CA_W-1:0]   k_q;
   logic [DATA_W-1:0] data_bank_q;
   logic [DATA_W-1:0] data_in_q;
   logic              err_q;
   logic [COLS-1:0]   col_mux_q, col_mux_nx;
   logic [DATA_W-1:0] data_and_q, data_and_nx;
   logic              accept;
   logic              out_of_range;
   logic              skip_exec;

   assign accept = bus.cmd_valid && (state == IDLE);

   always_comb begin
      out_of_range = (op_t'(bus.cmd_op) == OP_WRITE && int'(bus.cmd_bank) >= BANKS) ||
                     (op_t'(bus.cmd_op) == OP_READ  && int'(bus.cmd_col)  >= COLS);
      skip_exec    = out_of_range || (op_t'(bus.cmd_op) == OP_NOP);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= OP_NOP;
         bank_q      <= '0;
         col_q       <= '0;
         k_q         <= '0;
         data_bank_q <= '0;
         data_in_q   <= '0;
         err_q       <= 1'b0;
         col_mux_q   <= '0;
         data_and_q  <= '0;
      end else begin
         state      <= state_nx;
         col_mux_q  <= col_mux_nx;
         data_and_q <= data_and_nx;
         if (accept) begin
            op_q        <= op_t'(bus.cmd_op);
            bank_q      <= bus.cmd_bank;
            col_q       <= bus.cmd_col;
            data_bank_q <= bus.cmd_data_bank;
            data_in_q   <= bus.cmd_data_in;
            err_q       <= out_of_range;
            k_q         <= '0;
         end else if (state == EXEC && op_q == OP_MAC && k_q != CA_W'(COLS - 1)) begin
            k_q <= k_q + 1'b1;
         end
      end
   end

   // Adder-side controls are the registered copy of what EXEC computes.
   assign bus.col_mux  = col_mux_q;
   assign bus.data_and = data_and_q;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx      = state;
      bus.cmd_ready = 1'b0;
      bus.preb_en   = 1'b0;
      bus.mac_en    = 1'b1;
      bus.w_en      = 1'b0;
      bus.bank_mux  = '0;
      bus.data_op   = '0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      col_mux_nx    = '0;
      data_and_nx   = '0;

      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (accept) state_nx = skip_exec ? DRAIN : PRE;
         end
         PRE: begin
            bus.preb_en = 1'b1;
            state_nx    = EXEC;
         end
         EXEC: begin
            state_nx = DRAIN;
            case (op_q)
               OP_MAC: begin
                  bus.bank_mux = '1;
                  bus.data_op  = data_bank_q;
                  col_mux_nx   = COLS'(1) << k_q;
                  data_and_nx  = data_in_q;
                  if (k_q != CA_W'(COLS - 1)) state_nx = EXEC;
               end
               OP_WRITE: begin
                  bus.w_en     = 1'b1;
                  bus.bank_mux = BANKS'(1) << bank_q;
                  bus.data_op  = DATA_W'(data_bank_q[WR_W-1:0]);
               end
               OP_READ: begin
                  bus.mac_en   = 1'b0;
                  bus.bank_mux = '1;
                  bus.data_op  = DATA_W'(data_bank_q[RD_W-1:0]);
                  col_mux_nx   = COLS'(1) << col_q;
                  data_and_nx  = '1;
               end
               default: ;
            endcase
         end
         DRAIN: begin
            bus.done = 1'b1;
            bus.err  = err_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cim_array_seq.sv
// Directed, table-driven bench for cim_array_seq (16-bank instance plus a 12-bank range-check instance).
`timescale 1ns/1ps
module tb_cim_array_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cim_array_seq_if #(.BANKS(16), .COLS(8), .DATA_W(16)) bus ();
   cim_array_seq_if #(.BANKS(12), .COLS(8), .DATA_W(16)) bus12 ();

   cim_array_seq #(.BANKS(16), .COLS(8), .DATA_W(16), .WR_W(8), .RD_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
   cim_array_seq #(.BANKS(12), .COLS(8), .DATA_W(16), .WR_W(8), .RD_W(4)) dut12 (
      .clk(clk), .rst(rst), .bus(bus12.slave));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_preb"},  32'(bus.preb_en),  0);
      check({tag, "_mac"},   32'(bus.mac_en),   1);
      check({tag, "_wen"},   32'(bus.w_en),     0);
      check({tag, "_bmux"},  32'(bus.bank_mux), 0);
      check({tag, "_dop"},   32'(bus.data_op),  0);
      check({tag, "_cmux"},  32'(bus.col_mux),  0);
      check({tag, "_dand"},  32'(bus.data_and), 0);
      check({tag, "_done"},  32'(bus.done),     0);
      check({tag, "_err"},   32'(bus.err),      0);
   endtask

   // Waits (bounded) for ready at a falling edge, presents the command, returns just after edge A.
   task automatic issue(input logic [1:0] op, input logic [3:0] bank, input logic [2:0] col,
                        input logic [15:0] db, input logic [15:0] din);
      int waited = 0;
      while (bus.cmd_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_issue", 32'(bus.cmd_ready), 1);
      bus.cmd_op        = op;
      bus.cmd_bank      = bank;
      bus.cmd_col       = col;
      bus.cmd_data_bank = db;
      bus.cmd_data_in   = din;
      bus.cmd_valid     = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid  = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [3:0]  bank;
      logic [2:0]  col;
      logic [15:0] db;
      logic [15:0] din;
      int          lat;
      logic        e_w;
      logic        e_mac;
      logic [15:0] e_bank_mux;
      logic [15:0] e_data_op;
      logic [7:0]  e_col_mux;
      logic [15:0] e_data_and;
      logic        e_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{"write_b5",  2'b01, 4'd5,  3'd0, 16'h1234, 16'h0000, 3, 1'b1, 1'b1, 16'h0020, 16'h0034, 8'h00, 16'h0000, 1'b0};
      vecs[1] = '{"read_c6",   2'b10, 4'd0,  3'd6, 16'hBEEF, 16'h0000, 3, 1'b0, 1'b0, 16'hFFFF, 16'h000F, 8'h40, 16'hFFFF, 1'b0};
      vecs[2] = '{"nop",       2'b11, 4'd0,  3'd0, 16'h5555, 16'h5555, 1, 1'b0, 1'b1, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0};
      vecs[3] = '{"write_b15", 2'b01, 4'd15, 3'd0, 16'hABCD, 16'h0000, 3, 1'b1, 1'b1, 16'h8000, 16'h00CD, 8'h00, 16'h0000, 1'b0};
      vecs[4] = '{"read_c0",   2'b10, 4'd0,  3'd0, 16'h0001, 16'h0000, 3, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 8'h01, 16'hFFFF, 1'b0};
      vecs[5] = '{"read_c7",   2'b10, 4'd0,  3'd7, 16'hFFF0, 16'h0000, 3, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h80, 16'hFFFF, 1'b0};
      vecs[6] = '{"mac_0f0f",  2'b00, 4'd0,  3'd0, 16'h0F0F, 16'h3C3C, 10, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 8'h80, 16'h3C3C, 1'b0};

      bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_bank = '0; bus.cmd_col = '0;
      bus.cmd_data_bank = '0; bus.cmd_data_in = '0;
      bus12.cmd_valid = 1'b0; bus12.cmd_op = 2'b11; bus12.cmd_bank = '0; bus12.cmd_col = '0;
      bus12.cmd_data_bank = '0; bus12.cmd_data_in = '0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      check("reset_ready", 32'(bus.cmd_ready), 1);

      // MAC sweep from the test plan.
      issue(2'b00, 4'd0, 3'd0, 16'hA5A5, 16'h00FF);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("mac_c%0d_preb", c), 32'(bus.preb_en), (c == 1) ? 1 : 0);
         check($sformatf("mac_c%0d_bmux", c), 32'(bus.bank_mux), (c >= 2 && c <= 9) ? 32'hFFFF : 0);
         check($sformatf("mac_c%0d_dop", c),  32'(bus.data_op),  (c >= 2 && c <= 9) ? 32'hA5A5 : 0);
         check($sformatf("mac_c%0d_cmux", c), 32'(bus.col_mux),  (c >= 3) ? (32'd1 << (c - 3)) : 0);
         check($sformatf("mac_c%0d_dand", c), 32'(bus.data_and), (c >= 3) ? 32'h00FF : 0);
         check($sformatf("mac_c%0d_done", c), 32'(bus.done),     (c == 10) ? 1 : 0);
         check($sformatf("mac_c%0d_rdy", c),  32'(bus.cmd_ready), 0);
      end
      check("mac_err", 32'(bus.err), 0);
      @(negedge clk);
      check("mac_after_ready", 32'(bus.cmd_ready), 1);
      check_idle("mac_after");

      // Table-driven commands.
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].bank, vecs[i].col, vecs[i].db, vecs[i].din);
         for (int c = 1; c <= vecs[i].lat; c++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_done", vecs[i].name, c), 32'(bus.done), (c == vecs[i].lat) ? 1 : 0);
            if (c == 1)
               check({vecs[i].name, "_preb"}, 32'(bus.preb_en), (vecs[i].lat > 1) ? 1 : 0);
            if (c == 2 && vecs[i].lat > 1) begin
               check({vecs[i].name, "_wen"},  32'(bus.w_en),     32'(vecs[i].e_w));
               check({vecs[i].name, "_mac"},  32'(bus.mac_en),   32'(vecs[i].e_mac));
               check({vecs[i].name, "_bmux"}, 32'(bus.bank_mux), 32'(vecs[i].e_bank_mux));
               check({vecs[i].name, "_dop"},  32'(bus.data_op),  32'(vecs[i].e_data_op));
            end
            if (c == vecs[i].lat) begin
               check({vecs[i].name, "_err"},  32'(bus.err),      32'(vecs[i].e_err));
               check({vecs[i].name, "_cmux"}, 32'(bus.col_mux),  32'(vecs[i].e_col_mux));
               check({vecs[i].name, "_dand"}, 32'(bus.data_and), 32'(vecs[i].e_data_and));
               check({vecs[i].name, "_wen_d"}, 32'(bus.w_en), 0);
            end
         end
         @(negedge clk);
         check({vecs[i].name, "_ready_after"}, 32'(bus.cmd_ready), 1);
         check({vecs[i].name, "_done_after"},  32'(bus.done), 0);
      end

      // Command fields changing while busy must not disturb the latched command.
      issue(2'b01, 4'd3, 3'd0, 16'h00AA, 16'h0000);
      @(negedge clk);
      bus.cmd_bank = 4'd9; bus.cmd_data_bank = 16'hFFFF; bus.cmd_op = 2'b00;
      @(negedge clk);
      check("latched_bmux", 32'(bus.bank_mux), 32'h0008);
      check("latched_dop",  32'(bus.data_op),  32'h00AA);
      check("latched_wen",  32'(bus.w_en), 1);
      @(negedge clk);
      check("latched_done", 32'(bus.done), 1);
      @(negedge clk);

      // cmd_valid held high with NOP: done every other cycle.
      bus.cmd_op = 2'b11; bus.cmd_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("b2b_c%0d_done", c), 32'(bus.done), (c % 2 == 1) ? 1 : 0);
         check($sformatf("b2b_c%0d_rdy", c),  32'(bus.cmd_ready), (c % 2 == 0) ? 1 : 0);
      end
      bus.cmd_valid = 1'b0;
      @(negedge clk);

      // Reset pulsed in cycle 5 of a MAC: immediate idle outputs, no done.
      begin
         int dones = 0;
         issue(2'b00, 4'd0, 3'd0, 16'hA5A5, 16'h00FF);
         repeat (4) @(negedge clk);
         @(posedge clk);
         #2 rst = 1'b1;
         #1 check_idle("rst_mid");
         @(negedge clk);
         rst = 1'b0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
         end
         check("rst_no_done", 32'(dones), 0);
      end
      issue(2'b00, 4'd0, 3'd0, 16'h1111, 16'h2222);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("mac2_c%0d_done", c), 32'(bus.done), (c == 10) ? 1 : 0);
      end
      check("mac2_cmux", 32'(bus.col_mux),  32'h80);
      check("mac2_dand", 32'(bus.data_and), 32'h2222);
      check("mac2_err",  32'(bus.err), 0);

      // Range checks on the 12-bank instance.
      @(negedge clk);
      bus12.cmd_op = 2'b01; bus12.cmd_bank = 4'd13; bus12.cmd_data_bank = 16'h1234; bus12.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus12.cmd_valid = 1'b0;
      @(negedge clk);
      check("b12_oor13_done", 32'(bus12.done), 1);
      check("b12_oor13_err",  32'(bus12.err), 1);
      check("b12_oor13_wen",  32'(bus12.w_en), 0);
      check("b12_oor13_preb", 32'(bus12.preb_en), 0);
      @(negedge clk);
      check("b12_oor13_done2", 32'(bus12.done), 0);
      check("b12_oor13_rdy",   32'(bus12.cmd_ready), 1);
      check("b12_oor13_wen2",  32'(bus12.w_en), 0);

      bus12.cmd_bank = 4'd11; bus12.cmd_data_bank = 16'h00FF; bus12.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus12.cmd_valid = 1'b0;
      @(negedge clk);
      check("b12_w11_preb", 32'(bus12.preb_en), 1);
      @(negedge clk);
      check("b12_w11_wen",  32'(bus12.w_en), 1);
      check("b12_w11_bmux", 32'(bus12.bank_mux), 32'h800);
      check("b12_w11_dop",  32'(bus12.data_op), 32'h00FF);
      @(negedge clk);
      check("b12_w11_done", 32'(bus12.done), 1);
      check("b12_w11_err",  32'(bus12.err), 0);
      @(negedge clk);

      bus12.cmd_bank = 4'd12; bus12.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus12.cmd_valid = 1'b0;
      @(negedge clk);
      check("b12_oor12_done", 32'(bus12.done), 1);
      check("b12_oor12_err",  32'(bus12.err), 1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
